// File: rtl/demultiplexer_1to8.sv
// Registered 1-to-8 demultiplexer with unicast/broadcast routing and valid/ready handshakes.
// Optional per-channel transfer counters are built when DEMUX_COUNT_EN is defined.
module demultiplexer_1to8 #(
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned SEL_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic [SEL_WIDTH-1:0] in_sel,
    input  logic                 in_bcast,
    output logic [IN_WIDTH-1:0]  out_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ready,
    input  logic [SEL_WIDTH-1:0] cnt_sel,
    input  logic                 cnt_clr,
    output logic [15:0]          cnt_out
);

    logic [IN_WIDTH-1:0] data_q;
    logic [7:0]          pend_q;
    logic [7:0]          pend_done;
    logic [7:0]          pend_next;
    logic [7:0]          new_mask;
    logic                accept;

    always_comb begin
        pend_done = pend_q & out_ready;
        pend_next = pend_q & ~pend_done;
        // Ready as soon as every still-pending channel completes this cycle.
        in_ready  = ((pend_q & ~out_ready) == 8'h00);
        accept    = in_valid && in_ready;
        new_mask  = in_bcast ? 8'hFF : (8'h01 << in_sel);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            pend_q <= '0;
        end else begin
            if (accept) begin
                data_q <= in_data;
            end
            pend_q <= accept ? new_mask : pend_next;
        end
    end

    assign out_data  = data_q;
    assign out_valid = pend_q;

`ifdef DEMUX_COUNT_EN
    logic [15:0] cnt_q [8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                // Clear wins over a same-cycle increment; counters saturate.
                if (cnt_clr) begin
                    cnt_q[i] <= '0;
                end else if (pend_done[i] && (cnt_q[i] != 16'hFFFF)) begin
                    cnt_q[i] <= cnt_q[i] + 16'd1;
                end
            end
        end
    end

    assign cnt_out = cnt_q[cnt_sel];
`else
    logic unused_cnt;
    assign unused_cnt = ^{cnt_sel, cnt_clr};
    assign cnt_out    = '0;
`endif

endmodule

// File: tb/tb_demultiplexer_1to8.sv
// Directed self-checking bench for demultiplexer_1to8; counter checks follow DEMUX_COUNT_EN.
module tb_demultiplexer_1to8;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [2:0]  in_sel;
    logic        in_bcast;
    logic [31:0] out_data;
    logic [7:0]  out_valid;
    logic [7:0]  out_ready;
    logic [2:0]  cnt_sel;
    logic        cnt_clr;
    logic [15:0] cnt_out;

    int n_vec;
    int n_err;

    demultiplexer_1to8 #(
        .IN_WIDTH (32),
        .SEL_WIDTH(3)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_bcast (in_bcast),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .cnt_sel  (cnt_sel),
        .cnt_clr  (cnt_clr),
        .cnt_out  (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        in_bcast  = 1'b0;
        out_ready = 8'h00;
        cnt_sel   = '0;
        cnt_clr   = 1'b0;

        #3;
        chk("rst_out_valid", {24'h0, out_valid}, 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
        chk("rst_cnt_out", {16'h0, cnt_out}, 32'h0);
        #9;
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", {31'h0, in_ready}, 32'h1);
        step();

        // Unicast sweep, one word per cycle
        out_ready = 8'hFF;
        in_valid  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'(1000 * i);
            in_sel  = 3'(i);
            #1;
            chk("sweep_in_ready", {31'h0, in_ready}, 32'h1);
            step();
            chk("sweep_out_valid", {24'h0, out_valid}, 32'h1 << i);
            chk("sweep_out_data", out_data, 32'(1000 * i));
        end
        in_valid = 1'b0;
        step();
        chk("sweep_drain", {24'h0, out_valid}, 32'h0);

        // Stall on channel 5
        out_ready = 8'hDF;
        in_valid  = 1'b1;
        in_sel    = 3'd5;
        in_data   = 32'hDEAD_BEEF;
        step();
        in_data = 32'h1111_2222;
        for (int i = 0; i < 4; i++) begin
            chk("stall_out_valid", {24'h0, out_valid}, 32'h20);
            chk("stall_out_data", out_data, 32'hDEAD_BEEF);
            chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
            step();
        end
        out_ready = 8'hFF;
        #1;
        chk("stall_release_ready", {31'h0, in_ready}, 32'h1);
        step();
        in_valid = 1'b0;
        chk("stall_next_valid", {24'h0, out_valid}, 32'h20);
        chk("stall_next_data", out_data, 32'h1111_2222);
        step();
        chk("stall_drain", {24'h0, out_valid}, 32'h0);

        // Broadcast with partial acceptance
        in_valid  = 1'b1;
        in_bcast  = 1'b1;
        in_data   = 32'h1234_5678;
        out_ready = 8'h0F;
        step();
        in_valid = 1'b0;
        chk("bc_valid_1", {24'h0, out_valid}, 32'hFF);
        chk("bc_data", out_data, 32'h1234_5678);
        chk("bc_ready_1", {31'h0, in_ready}, 32'h0);
        step();
        out_ready = 8'hF0;
        #1;
        chk("bc_valid_2", {24'h0, out_valid}, 32'hF0);
        chk("bc_ready_2", {31'h0, in_ready}, 32'h1);
        step();
        chk("bc_valid_3", {24'h0, out_valid}, 32'h0);
        in_bcast  = 1'b0;
        out_ready = 8'hFF;

`ifdef DEMUX_COUNT_EN
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        cnt_sel = 3'd2;
        #1;
        chk("cnt_cleared", {16'h0, cnt_out}, 32'h0);
        in_valid = 1'b1;
        in_sel   = 3'd2;
        step();
        step();
        step();
        in_sel = 3'd7;
        step();
        in_valid = 1'b0;
        step();
        cnt_sel = 3'd2;
        #1;
        chk("cnt_ch2", {16'h0, cnt_out}, 32'd3);
        cnt_sel = 3'd7;
        #1;
        chk("cnt_ch7", {16'h0, cnt_out}, 32'd1);
        cnt_sel = 3'd0;
        #1;
        chk("cnt_ch0", {16'h0, cnt_out}, 32'd0);
        in_valid = 1'b1;
        in_sel   = 3'd2;
        step();
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        step();
        cnt_clr = 1'b0;
        cnt_sel = 3'd2;
        #1;
        chk("cnt_clr_priority", {16'h0, cnt_out}, 32'd0);
        chk("cnt_clr_drained", {24'h0, out_valid}, 32'h0);
`else
        cnt_clr = 1'b1;
        cnt_sel = 3'd2;
        #1;
        chk("nocnt_ch2", {16'h0, cnt_out}, 32'h0);
        cnt_clr = 1'b0;
        cnt_sel = 3'd7;
        #1;
        chk("nocnt_ch7", {16'h0, cnt_out}, 32'h0);
`endif

        // Asynchronous reset while a broadcast is pending
        out_ready = 8'h00;
        in_valid  = 1'b1;
        in_bcast  = 1'b1;
        in_data   = 32'hCAFE_F00D;
        step();
        in_valid = 1'b0;
        chk("mr_pending", {24'h0, out_valid}, 32'hFF);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_out_valid", {24'h0, out_valid}, 32'h0);
        chk("mr_out_data", out_data, 32'h0);
        chk("mr_in_ready", {31'h0, in_ready}, 32'h1);
        chk("mr_cnt_out", {16'h0, cnt_out}, 32'h0);
        #1;
        rst_n = 1'b1;
        step();
        chk("mr_after_valid", {24'h0, out_valid}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/demultiplexer_1to8.md
# demultiplexer_1to8

Registered 1-to-8 demultiplexer and the write-side counterpart of the 8-to-1 operand multiplexer in the ALU datapath. It accepts one word per cycle on a valid/ready input, latches it, and presents it to the selected output channel, or to all eight channels in broadcast mode, until every addressed channel has accepted it. Throughput is one word per cycle when the addressed channels are ready.

## Interface
Parameters:
- IN_WIDTH, 32, data word width
- SEL_WIDTH, 3, select width; channel count = 1 << SEL_WIDTH (8; ports sized for 8)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input word present
- in_ready  output  1  block accepts input this cycle
- in_data  input  IN_WIDTH  input word
- in_sel  input  SEL_WIDTH  destination channel (ignored when in_bcast=1)
- in_bcast  input  1  route the word to all 8 channels
- out_data  output  IN_WIDTH  held word, shared by all channels
- out_valid  output  8  per-channel valid (bit i = channel i)
- out_ready  input  8  per-channel ready
- cnt_sel  input  SEL_WIDTH  channel whose transfer count is read
- cnt_clr  input  1  synchronous clear of all counters
- cnt_out  output  16  transfer count of channel cnt_sel

## Operation
- State: holding register data_q[IN_WIDTH] and pending mask pend_q[8]. out_data = data_q; out_valid = pend_q.
- Channel i transfer: out_valid[i] && out_ready[i] in the same cycle.
- Each cycle, pend_next = pend_q & ~(pend_q & out_ready).
- in_ready = ((pend_q & ~out_ready) == 0), meaning the register is empty or every still-pending channel completes this cycle. This is a combinational path from out_ready to in_ready and is required.
- Accept (in_valid && in_ready):
  - data_q <= in_data.
  - pend_q <= 8'hFF if in_bcast, else one-hot(in_sel).
  - The new mask replaces pend_next.
- No accept: pend_q <= pend_next. data_q holds.
- Broadcast:
  - Channels may accept in any cycles and any order.
  - A channel that has accepted drops its out_valid and does not see the word again.
  - The next word is accepted only in the cycle the last pending channel accepts.
- out_data changes only on accept. It stays stable while any out_valid bit is high.
- The block has no state machine beyond pend_q. Empty means pend_q == 0.

## Timing
- Reset (asynchronous, rst_n low): pend_q=0, data_q=0, all counters=0. Outputs: out_valid=0, out_data=0, cnt_out=0. in_ready=1 while in reset and after release.
- Latency: a word accepted at edge N is visible on out_data/out_valid after edge N (the same cycle N+1 that the next word may be offered).
- Back-to-back: if the addressed channels hold out_ready=1, one word transfers per cycle with no bubbles.
- Stall: if an addressed channel holds out_ready=0, in_ready=0 and pend_q, data_q and out_data hold indefinitely.
- out_ready on a channel with out_valid=0 is ignored and is not counted.
- Reset mid-operation drops the held word. No transfer is reported for it.

## Configuration
- DEMUX_COUNT_EN defined:
  - Eight 16-bit per-channel transfer counters. Channel i increments on each channel-i transfer and saturates at 16'hFFFF.
  - cnt_clr=1 clears all counters at the next edge and takes priority over an increment in the same cycle.
  - cnt_out = counter[cnt_sel], combinational.
- DEMUX_COUNT_EN undefined: no counters are built, cnt_out is tied to 0, and cnt_sel/cnt_clr are ignored. The datapath is identical in both builds.

## Test plan
- Unicast sweep: out_ready=8'hFF, send in_data=1000*i with in_sel=i for i=0..7 on consecutive cycles -> each cycle exactly out_valid[i] is set with out_data=1000*i; in_ready stays 1; 8 words in 8 cycles.
- Stall: in_sel=5, data=32'hDEAD_BEEF, out_ready[5]=0 for 4 cycles -> out_valid=8'h20 and out_data stable, in_ready=0; raising out_ready[5] frees in_ready in the same cycle.
- Broadcast partial accept: in_bcast=1, data=32'h1234_5678, out_ready=8'h0F then 8'hF0 -> out_valid 8'hFF, then 8'hF0, then 0; in_ready=1 only in the second cycle.
- Reset mid-operation: pending broadcast with out_ready=0, pulse rst_n low asynchronously mid-cycle -> out_valid=0 and out_data=0 immediately, in_ready=1.
- Counters (DEMUX_COUNT_EN): 3 transfers to channel 2 and 1 to channel 7 -> cnt_sel=2 gives 3, cnt_sel=7 gives 1; cnt_clr coinciding with a channel-2 transfer -> 0. Without the macro, cnt_out=0 throughout.
